sdram_port_arbiter: RTL

- Two-port front end that sits directly upstream of the SDRAM controller and is its only client.
- Port A (instruction fetch, read-only) and port B (data, read/write) compete for the controller. The block serializes their requests with round-robin arbitration and latches the granted request.
- It drives the controller's start/addr/we/d handshake and returns read data with a one-cycle ack pulse.

---
 rtl/sdram_pkg.sv | 18 +
 rtl/rr_arbiter2.sv | 37 +++
 rtl/sdram_port_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM controller front end: state encoding,
// port identifiers and default bus widths.
package sdram_pkg;

  localparam int SDRAM_ADDR_W = 24;
  localparam int SDRAM_DATA_W = 32;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef enum logic [1:0] {
    S_WAIT_INIT = 2'd0,
    S_IDLE      = 2'd1,
    S_ISSUE     = 2'd2,
    S_RELEASE   = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter: combinational grant, registered pointer
// that flips to the losing side whenever a grant is taken.
module rr_arbiter2
  import sdram_pkg::*;
#(
  parameter bit B_FIRST = 1'b1
) (
  input  logic clk,
  input  logic resetn,
  input  logic req_a,
  input  logic req_b,
  input  logic en,
  output logic gnt_vld,
  output logic gnt_port
);

  logic rr_ptr;

  always_comb begin
    gnt_vld = en && (req_a || req_b);
    if (req_a && req_b) begin
      gnt_port = rr_ptr;
    end else begin
      gnt_port = req_b ? PORT_B : PORT_A;
    end
  end

  // rr_ptr=1 favours port B on the next contended grant.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_ptr <= B_FIRST;
    end else if (gnt_vld) begin
      rr_ptr <= ~gnt_port;
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Two-port front end for the SDRAM controller: round-robin arbitration between
// instruction fetch (A) and data (B), start/ready handshake, ack pulse return.
module sdram_port_arbiter
  import sdram_pkg::*;
#(
  parameter int ADDR_W  = SDRAM_ADDR_W,
  parameter int DATA_W  = SDRAM_DATA_W,
  parameter bit B_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_q,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic              b_we,
  input  logic [DATA_W-1:0] b_d,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_q,
  input  logic              mem_init_done,
  input  logic              mem_busy,
  output logic              mem_start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_d,
  input  logic [DATA_W-1:0] mem_q,
  input  logic              mem_q_ready
);

  state_t            state_q, state_d;
  logic              gnt_port_q, gnt_port_d;
  logic              start_d, we_d, a_ack_d, b_ack_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] d_d, a_q_d, b_q_d;
  logic              arb_en, gnt_vld, gnt_port;

  // Arbitration is only offered while idle and the controller is not refreshing.
  assign arb_en = (state_q == S_IDLE) && !mem_busy;

  rr_arbiter2 #(
    .B_FIRST (B_FIRST)
  ) u_arb (
    .clk      (clk),
    .resetn   (resetn),
    .req_a    (a_req),
    .req_b    (b_req),
    .en       (arb_en),
    .gnt_vld  (gnt_vld),
    .gnt_port (gnt_port)
  );

  always_comb begin
    state_d    = state_q;
    gnt_port_d = gnt_port_q;
    start_d    = mem_start;
    addr_d     = mem_addr;
    we_d       = mem_we;
    d_d        = mem_d;
    a_q_d      = a_q;
    b_q_d      = b_q;
    a_ack_d    = 1'b0;
    b_ack_d    = 1'b0;
    case (state_q)
      S_WAIT_INIT: begin
        if (mem_init_done) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (gnt_vld) begin
          gnt_port_d = gnt_port;
          start_d    = 1'b1;
          state_d    = S_ISSUE;
          if (gnt_port == PORT_B) begin
            addr_d = b_addr;
            we_d   = b_we;
            d_d    = b_d;
          end else begin
            addr_d = a_addr;
            we_d   = 1'b0;
            d_d    = '0;
          end
        end
      end
      S_ISSUE: begin
        // Address/data stay latched from the grant until the controller completes.
        if (mem_q_ready) begin
          start_d = 1'b0;
          state_d = S_RELEASE;
          if (gnt_port_q == PORT_B) begin
            b_ack_d = 1'b1;
            if (!mem_we) b_q_d = mem_q;
          end else begin
            a_ack_d = 1'b1;
            if (!mem_we) a_q_d = mem_q;
          end
        end
      end
      S_RELEASE: begin
        if (!mem_busy) state_d = S_IDLE;
      end
      default: state_d = S_WAIT_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_WAIT_INIT;
      gnt_port_q <= PORT_A;
      mem_start  <= 1'b0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_d      <= '0;
      a_ack      <= 1'b0;
      b_ack      <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
    end else begin
      state_q    <= state_d;
      gnt_port_q <= gnt_port_d;
      mem_start  <= start_d;
      mem_addr   <= addr_d;
      mem_we     <= we_d;
      mem_d      <= d_d;
      a_ack      <= a_ack_d;
      b_ack      <= b_ack_d;
      a_q        <= a_q_d;
      b_q        <= b_q_d;
    end
  end

endmodule
